addsub_pipe: RTL and testbench

Parametrised, registered two's-complement adder/subtractor with optional signed saturation, a running accumulator and valid/ready handshakes on both sides. It is the next-generation arithmetic unit for the datapath: the same add/subtract-with-carry function, generalised to any width, with four operations, status flags, and flow control so it can sit between producer and consumer stages.

---
 rtl/addsub_pipe.sv | 105 ++++++++++
 tb/tb_addsub_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Registered two's-complement adder/subtractor with running accumulator,
// optional signed saturation and valid/ready flow control on both sides.
module addsub_pipe #(
    parameter int WIDTH = 8,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [WIDTH-1:0] acc
);

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             accept;
    logic             is_acc;
    logic             is_sub;
    logic [WIDTH-1:0] first_opnd;
    logic [WIDTH-1:0] second_raw;
    logic [WIDTH-1:0] addend;
    logic             carry;
    logic [WIDTH:0]   raw_sum;
    logic             ovf_next;
    logic [WIDTH-1:0] result_next;

    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             ovf_reg;
    logic             zero_reg;
    logic             neg_reg;
    logic [WIDTH-1:0] acc_reg;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_acc   = op[1];
    assign is_sub   = op[0];

    // Subtraction is a + ~b + ~borrow, so one adder serves all four ops.
    always_comb begin
        first_opnd  = is_acc ? (clr_acc ? '0 : acc_reg) : a;
        second_raw  = is_acc ? a : b;
        addend      = is_sub ? ~second_raw : second_raw;
        carry       = is_sub ? ~cin : cin;
        raw_sum     = {1'b0, first_opnd} + {1'b0, addend} + {{WIDTH{1'b0}}, carry};
        ovf_next    = (first_opnd[WIDTH-1] == addend[WIDTH-1]) &&
                      (raw_sum[WIDTH-1] != first_opnd[WIDTH-1]);
        result_next = raw_sum[WIDTH-1:0];
        if (SAT && ovf_next) begin
            result_next = first_opnd[WIDTH-1] ? SAT_NEG : SAT_POS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
            neg_reg       <= 1'b0;
            acc_reg       <= '0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                result_reg    <= result_next;
                cout_reg      <= raw_sum[WIDTH];
                ovf_reg       <= ovf_next;
                zero_reg      <= (result_next == '0);
                neg_reg       <= result_next[WIDTH-1];
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            // An accepted ACC op already folded clr_acc into its operand.
            if (accept && is_acc) begin
                acc_reg <= result_next;
            end else if (clr_acc) begin
                acc_reg <= '0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
    assign zero      = zero_reg;
    assign neg       = neg_reg;
    assign acc       = acc_reg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: one 8-bit wrap-around instance and two
// 4-bit instances (wrap and saturating) driven with identical operands.
module tb_addsub_pipe;

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        logic       zero;
        logic       neg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       iv8, ir8, ov8, or8, cin8, clr8, co8, ovf8, z8, n8;
    logic [7:0] a8, b8, r8, acc8;
    logic [1:0] op8;

    logic       iv4, cin4, clr4, or4;
    logic [3:0] a4, b4;
    logic [1:0] op4;
    logic       ir4w, ov4w, co4w, ovf4w, z4w, n4w;
    logic [3:0] r4w, acc4w;
    logic       ir4s, ov4s, co4s, ovf4s, z4s, n4s;
    logic [3:0] r4s, acc4s;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q8[$];
    exp_t q4w[$];
    exp_t q4s[$];
    logic [7:0] acc_m;
    exp_t e;
    exp_t got;

    addsub_pipe #(.WIDTH(8), .SAT(1'b0)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .op(op8), .cin(cin8), .clr_acc(clr8), .out_valid(ov8), .out_ready(or8),
        .result(r8), .cout(co8), .ovf(ovf8), .zero(z8), .neg(n8), .acc(acc8));

    addsub_pipe #(.WIDTH(4), .SAT(1'b0)) u4w (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4w), .a(a4), .b(b4),
        .op(op4), .cin(cin4), .clr_acc(clr4), .out_valid(ov4w), .out_ready(or4),
        .result(r4w), .cout(co4w), .ovf(ovf4w), .zero(z4w), .neg(n4w), .acc(acc4w));

    addsub_pipe #(.WIDTH(4), .SAT(1'b1)) u4s (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4s), .a(a4), .b(b4),
        .op(op4), .cin(cin4), .clr_acc(clr4), .out_valid(ov4s), .out_ready(or4),
        .result(r4s), .cout(co4s), .ovf(ovf4s), .zero(z4s), .neg(n4s), .acc(acc4s));

    // Integer reference model for the 8-bit wrap-around instance.
    function automatic exp_t model8(input logic [7:0] accv, input logic [7:0] x,
                                    input logic [7:0] y, input logic [1:0] opv,
                                    input logic c, input logic clr);
        int f, s, sf, ss, u, sv, ci;
        exp_t r;
        ci = c ? 1 : 0;
        f  = opv[1] ? (clr ? 0 : int'(accv)) : int'(x);
        s  = opv[1] ? int'(x) : int'(y);
        sf = (f > 127) ? f - 256 : f;
        ss = (s > 127) ? s - 256 : s;
        if (opv[0]) begin
            u  = f + (255 - s) + (1 - ci);
            sv = sf - ss - ci;
        end else begin
            u  = f + s + ci;
            sv = sf + ss + ci;
        end
        r.res  = u[7:0];
        r.cout = u[8];
        r.ovf  = (sv > 127) || (sv < -128);
        r.zero = (u[7:0] == 8'h00);
        r.neg  = u[7];
        return r;
    endfunction

    // Record the expected outcome of the 8-bit operand set about to be accepted.
    function automatic void push8();
        exp_t r;
        r = model8(acc_m, a8, b8, op8, cin8, clr8);
        q8.push_back(r);
        if (op8[1]) acc_m = r.res;
        else if (clr8) acc_m = 8'h00;
    endfunction

    function automatic exp_t mk4(input logic [3:0] res, input logic c, input logic o,
                                 input logic z, input logic n);
        exp_t r;
        r.res = {4'h0, res}; r.cout = c; r.ovf = o; r.zero = z; r.neg = n;
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        iv8 = 0; or8 = 1; a8 = 0; b8 = 0; op8 = 0; cin8 = 0; clr8 = 0;
        iv4 = 0; or4 = 1; a4 = 0; b4 = 0; op4 = 0; cin4 = 0; clr4 = 0;
        acc_m = 8'h00;
        #17;
        n_checks++;
        if ({ov8, r8, co8, ovf8, z8, n8, acc8} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h required 0", {ov8, r8, co8, ovf8, z8, n8, acc8});
        end
        n_checks++;
        if (ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", ir8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add4();
        iv4 = 1; op4 = 2'b00; a4 = 4'hF; b4 = 4'hF; cin4 = 0;
        q4w.push_back(mk4(4'hE, 1, 0, 0, 1));
        q4s.push_back(mk4(4'hE, 1, 0, 0, 1));
        @(posedge clk); #1;
        iv4 = 0;
        e = q4w.pop_front(); got = {4'h0, r4w, co4w, ovf4w, z4w, n4w}; n_checks++;
        if (ov4w !== 1'b1 || got !== e) begin
            n_fail++;
            $display("FAIL add4_wrap: got v=%b %h required v=1 %h", ov4w, got, e);
        end
        e = q4s.pop_front(); got = {4'h0, r4s, co4s, ovf4s, z4s, n4s}; n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL add4_sat: got %h required %h", got, e);
        end
    endtask

    task automatic test_sub4();
        logic [3:0] va[3] = '{4'h0, 4'h1, 4'h1};
        logic [3:0] vb[3] = '{4'hC, 4'h1, 4'h0};
        logic       vc[3] = '{1'b0, 1'b0, 1'b1};
        exp_t       ve[3];
        ve[0] = mk4(4'h4, 0, 0, 0, 0);
        ve[1] = mk4(4'h0, 1, 0, 1, 0);
        ve[2] = mk4(4'h0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            iv4 = 1; op4 = 2'b01; a4 = va[i]; b4 = vb[i]; cin4 = vc[i];
            q4w.push_back(ve[i]);
            q4s.push_back(ve[i]);
            @(posedge clk); #1;
            e = q4w.pop_front(); got = {4'h0, r4w, co4w, ovf4w, z4w, n4w}; n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL sub4_wrap[%0d]: got %h required %h", i, got, e);
            end
            e = q4s.pop_front(); got = {4'h0, r4s, co4s, ovf4s, z4s, n4s}; n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL sub4_sat[%0d]: got %h required %h", i, got, e);
            end
        end
        iv4 = 0; cin4 = 0;
    endtask

    task automatic test_saturation();
        iv4 = 1; op4 = 2'b00; a4 = 4'h7; b4 = 4'h1; cin4 = 0;
        q4w.push_back(mk4(4'h8, 0, 1, 0, 1));
        q4s.push_back(mk4(4'h7, 0, 1, 0, 0));
        @(posedge clk); #1;
        op4 = 2'b01; a4 = 4'h8; b4 = 4'h1;
        e = q4w.pop_front(); got = {4'h0, r4w, co4w, ovf4w, z4w, n4w}; n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL ovf_add_wrap: got %h required %h", got, e);
        end
        e = q4s.pop_front(); got = {4'h0, r4s, co4s, ovf4s, z4s, n4s}; n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL ovf_add_sat: got %h required %h", got, e);
        end
        q4w.push_back(mk4(4'h7, 1, 1, 0, 0));
        q4s.push_back(mk4(4'h8, 1, 1, 0, 1));
        @(posedge clk); #1;
        iv4 = 0;
        e = q4w.pop_front(); got = {4'h0, r4w, co4w, ovf4w, z4w, n4w}; n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL ovf_sub_wrap: got %h required %h", got, e);
        end
        e = q4s.pop_front(); got = {4'h0, r4s, co4s, ovf4s, z4s, n4s}; n_checks++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL ovf_sub_sat: got %h required %h", got, e);
        end
    endtask

    task automatic test_accumulate();
        logic [1:0] vop[5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b11};
        logic [7:0] va[5]  = '{8'd3, 8'd3, 8'd3, 8'h10, 8'd9};
        logic       vclr[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] vacc[5] = '{8'd3, 8'd6, 8'd9, 8'd9, 8'd0};
        or8 = 1;
        for (int i = 0; i < 5; i++) begin
            iv8 = 1; op8 = vop[i]; a8 = va[i]; b8 = 8'h20; cin8 = 0; clr8 = vclr[i];
            push8();
            @(posedge clk); #1;
            e = q8.pop_front(); n_checks++;
            if ({r8, co8, ovf8, z8, n8} !== e) begin
                n_fail++;
                $display("FAIL accum_result[%0d]: got %h required %h", i, {r8, co8, ovf8, z8, n8}, e);
            end
            n_checks++;
            if (acc8 !== vacc[i]) begin
                n_fail++;
                $display("FAIL accum_acc[%0d]: got %h required %h", i, acc8, vacc[i]);
            end
        end
        n_checks++;
        if (z8 !== 1'b1) begin
            n_fail++;
            $display("FAIL accum_zero: got %b required 1", z8);
        end
        iv8 = 0; clr8 = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [11:0] held;
        logic [7:0]  hacc;
        iv8 = 1; or8 = 1; op8 = 2'b00; a8 = 8'h05; b8 = 8'h06; cin8 = 0; clr8 = 0;
        push8();
        @(posedge clk); #1;
        e = q8.pop_front(); n_checks++;
        if ({r8, co8, ovf8, z8, n8} !== e) begin
            n_fail++;
            $display("FAIL bp_first: got %h required %h", {r8, co8, ovf8, z8, n8}, e);
        end
        held = e; hacc = acc_m;
        or8 = 0; op8 = 2'b10; a8 = 8'h01;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (ir8 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_in_ready[%0d]: got %b required 0", i, ir8);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({ov8, r8, co8, ovf8, z8, n8, acc8} !== {1'b1, held, hacc}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %h required %h", i,
                         {ov8, r8, co8, ovf8, z8, n8, acc8}, {1'b1, held, hacc});
            end
        end
        or8 = 1; #1;
        n_checks++;
        if (ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b required 1", ir8);
        end
        push8();
        @(posedge clk); #1;
        iv8 = 0;
        e = q8.pop_front(); n_checks++;
        if ({ov8, r8, co8, ovf8, z8, n8} !== {1'b1, e} || acc8 !== acc_m) begin
            n_fail++;
            $display("FAIL bp_resume: got v=%b %h acc=%h required v=1 %h acc=%h",
                     ov8, {r8, co8, ovf8, z8, n8}, acc8, e, acc_m);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ov8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got out_valid=%b required 0", ov8);
        end
    endtask

    task automatic test_reset_mid();
        iv8 = 1; or8 = 1; op8 = 2'b10; a8 = 8'h55; cin8 = 0; clr8 = 1;
        push8();
        @(posedge clk); #1;
        iv8 = 0; clr8 = 0; or8 = 0;
        e = q8.pop_front(); n_checks++;
        if ({r8, co8, ovf8, z8, n8} !== e || acc8 !== 8'h55) begin
            n_fail++;
            $display("FAIL rst_setup: got %h acc=%h required %h acc=55", {r8, co8, ovf8, z8, n8}, acc8, e);
        end
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        acc_m = 8'h00;
        n_checks++;
        if ({ov8, r8, co8, ovf8, z8, n8, acc8} !== 21'h0 || ir8 !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: got %h ready=%b required 0 ready=1",
                     {ov8, r8, co8, ovf8, z8, n8, acc8}, ir8);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        iv8 = 1; or8 = 1; op8 = 2'b00; a8 = 8'h01; b8 = 8'h02;
        push8();
        @(posedge clk); #1;
        iv8 = 0;
        e = q8.pop_front(); n_checks++;
        if ({ov8, r8, co8, ovf8, z8, n8, acc8} !== {1'b1, e, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_first_accept: got %h required %h",
                     {ov8, r8, co8, ovf8, z8, n8, acc8}, {1'b1, e, 8'h00});
        end
    endtask

    initial begin
        test_reset();
        test_add4();
        test_sub4();
        test_saturation();
        test_accumulate();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
